uart_block_assembler: RTL and testbench

Downstream consumer of the UART receiver. Packs the receiver's one-cycle byte strobes into 64-bit blocks for the DES core. The first byte received lands in the MSB. The block is double-buffered: one assembly register plus one output register with a valid/ready handshake toward the DES core. It also discards stale partial blocks after an inter-byte idle timeout and flags bytes dropped on overflow.

---
 rtl/uart_block_assembler_pkg.sv | 22 ++
 rtl/uart_idle_timer.sv | 34 +++
 rtl/uart_block_assembler.sv | 121 ++++++++++++
 tb/tb_uart_block_assembler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_block_assembler_pkg.sv
// Shared types and constants for the UART-to-DES block assembler.
// Holds the assembly state encoding and the byte-append helper.
package uart_block_assembler_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'h0,
    ACCUM = 2'h1,
    HELD  = 2'h2
  } asm_state_t;

  localparam int BLOCK_BYTES = 8;
  localparam int DES_BLOCK_W = 64;

  // Oldest byte drifts toward the MSB as new bytes enter at the bottom.
  function automatic logic [DES_BLOCK_W-1:0] shift_in(
    input logic [DES_BLOCK_W-1:0] blk,
    input logic [7:0]             b
  );
    return {blk[DES_BLOCK_W-9:0], b};
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer: counts while enabled, o_Tc flags the last idle cycle.
// Wraps to zero on terminal count so it can never overflow its width.
module uart_idle_timer #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TMR_W          = 16
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Tc
);

  localparam logic [TMR_W-1:0] LP_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] r_Count;
  logic             w_AtLast;

  assign w_AtLast = (r_Count == LP_LAST);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Count <= '0;
    end else if (i_Clear) begin
      r_Count <= '0;
    end else if (i_Enable) begin
      r_Count <= w_AtLast ? '0 : r_Count + 1'b1;
    end
  end

  // A clear in the same cycle (new byte) overrides expiry.
  assign o_Tc = i_Enable && !i_Clear && w_AtLast;

endmodule

// File: rtl/uart_block_assembler.sv
// Packs UART byte strobes into 64-bit blocks, first byte in the MSB, with a
// double-buffered valid/ready output, idle timeout and overflow flagging.
module uart_block_assembler
  import uart_block_assembler_pkg::*;
#(
  parameter int BLOCK_BYTES    = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TMR_W          = 16
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_fDone,
  input  logic [7:0]             i_Data,
  input  logic                   i_Ready,
  output logic                   o_Valid,
  output logic [DES_BLOCK_W-1:0] o_Block,
  output logic                   o_fOvf,
  output logic                   o_fTimeout,
  output logic [3:0]             o_Cnt
);

  asm_state_t             r_State;
  logic [DES_BLOCK_W-1:0] r_Asm;
  logic [3:0]             r_Cnt;
  logic                   r_Valid;
  logic [DES_BLOCK_W-1:0] r_Block;
  logic                   r_fOvf;
  logic                   r_fTimeout;

  logic                   w_OutFree;
  logic                   w_LastByte;
  logic                   w_TmrClear;
  logic                   w_TmrEnable;
  logic                   w_Tc;
  logic [DES_BLOCK_W-1:0] w_AsmShift;

  assign w_OutFree   = !r_Valid || i_Ready;
  assign w_LastByte  = (r_Cnt == 4'(BLOCK_BYTES - 1));
  assign w_AsmShift  = shift_in(r_Asm, i_Data);
  assign w_TmrEnable = (r_State == ACCUM);
  assign w_TmrClear  = i_fDone || (r_State != ACCUM);

  uart_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_idle_timer (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Clear (w_TmrClear),
    .i_Enable(w_TmrEnable),
    .o_Tc    (w_Tc)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State    <= EMPTY;
      r_Asm      <= '0;
      r_Cnt      <= '0;
      r_Valid    <= 1'b0;
      r_Block    <= '0;
      r_fOvf     <= 1'b0;
      r_fTimeout <= 1'b0;
    end else begin
      r_fOvf     <= 1'b0;
      r_fTimeout <= 1'b0;
      // Consumed output drops unless a transfer below refills it this cycle.
      if (r_Valid && i_Ready) begin
        r_Valid <= 1'b0;
      end

      case (r_State)
        HELD: begin
          if (i_fDone) begin
            r_fOvf <= 1'b1;
          end
          if (w_OutFree) begin
            r_Block <= r_Asm;
            r_Valid <= 1'b1;
            r_Asm   <= '0;
            r_Cnt   <= '0;
            r_State <= EMPTY;
          end
        end

        default: begin
          if (i_fDone) begin
            if (w_LastByte) begin
              if (w_OutFree) begin
                r_Block <= w_AsmShift;
                r_Valid <= 1'b1;
                r_Asm   <= '0;
                r_Cnt   <= '0;
                r_State <= EMPTY;
              end else begin
                r_Asm   <= w_AsmShift;
                r_Cnt   <= 4'(BLOCK_BYTES);
                r_State <= HELD;
              end
            end else begin
              r_Asm   <= w_AsmShift;
              r_Cnt   <= r_Cnt + 4'd1;
              r_State <= ACCUM;
            end
          end else if (w_Tc) begin
            r_Asm      <= '0;
            r_Cnt      <= '0;
            r_State    <= EMPTY;
            r_fTimeout <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_Valid    = r_Valid;
  assign o_Block    = r_Block;
  assign o_fOvf     = r_fOvf;
  assign o_fTimeout = r_fTimeout;
  assign o_Cnt      = r_Cnt;

endmodule

// File: tb/tb_uart_block_assembler.sv
// Bench for uart_block_assembler: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_uart_block_assembler;

  localparam int T = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        fdone;
  logic [7:0]  data;
  logic        ready;
  logic        valid;
  logic [63:0] block;
  logic        ovf;
  logic        tmo;
  logic [3:0]  cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  q_asm[$];
  bit          m_valid;
  logic [63:0] m_block;
  int          m_idle;
  bit          m_ovf;
  bit          m_tmo;

  uart_block_assembler #(
    .BLOCK_BYTES   (8),
    .TIMEOUT_CYCLES(T),
    .TMR_W         (16)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_fDone   (fdone),
    .i_Data    (data),
    .i_Ready   (ready),
    .o_Valid   (valid),
    .o_Block   (block),
    .o_fOvf    (ovf),
    .o_fTimeout(tmo),
    .o_Cnt     (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q_asm.delete();
    m_valid = 0;
    m_block = '0;
    m_idle  = 0;
    m_ovf   = 0;
    m_tmo   = 0;
  endtask

  // Cycle behaviour of the assembler expressed over a byte queue.
  task automatic model_step(input bit fd, input logic [7:0] d, input bit rdy);
    bit free;
    bit xfer;
    logic [63:0] nb;
    free  = !m_valid || rdy;
    xfer  = 0;
    m_ovf = 0;
    m_tmo = 0;
    if (m_valid && rdy) $display("block taken: %h", m_block);
    if (q_asm.size() == 8) begin
      if (fd) m_ovf = 1;
      if (free) xfer = 1;
    end else if (fd) begin
      q_asm.push_back(d);
      m_idle = 0;
      if (q_asm.size() == 8 && free) xfer = 1;
    end else if (q_asm.size() > 0) begin
      if (m_idle == T - 1) begin
        q_asm.delete();
        m_tmo  = 1;
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end
    if (xfer) begin
      nb = '0;
      foreach (q_asm[i]) nb = (nb << 8) | 64'(q_asm[i]);
      m_block = nb;
      q_asm.delete();
    end
    m_valid = xfer || (m_valid && !rdy);
  endtask

  task automatic step(input bit fd, input logic [7:0] d, input bit rdy);
    fdone = fd;
    data  = d;
    ready = rdy;
    model_step(fd, d, rdy);
    @(posedge clk);
    #1;
    chk("valid", 64'(valid), 64'(m_valid));
    if (m_valid) chk("block", block, m_block);
    chk("cnt", 64'(cnt), 64'(q_asm.size()));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("timeout", 64'(tmo), 64'(m_tmo));
  endtask

  initial begin
    int waited;
    rst   = 1'b1;
    fdone = 1'b0;
    data  = 8'h00;
    ready = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_block", block, 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_flags", 64'({ovf, tmo}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single block with ready held high
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 1);
    chk("blk1", block, 64'h0102030405060708);
    chk("blk1_valid", 64'(valid), 64'd1);
    step(0, 0, 1);
    chk("blk1_drop", 64'(valid), 64'd0);

    // Two blocks with the output stalled, then back-to-back drain
    for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0);
    chk("stall_blk", block, 64'h1011121314151617);
    chk("stall_cnt", 64'(cnt), 64'd8);
    step(0, 0, 1);
    chk("b2b_valid", 64'(valid), 64'd1);
    chk("b2b_blk", block, 64'h18191A1B1C1D1E1F);
    step(0, 0, 1);
    chk("b2b_drop", 64'(valid), 64'd0);

    // Overflow: both registers full, extra byte dropped
    for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0);
    step(1, 8'hAA, 0);
    chk("ovf_pulse", 64'(ovf), 64'd1);
    step(0, 0, 0);
    chk("ovf_once", 64'(ovf), 64'd0);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("ovf_clean", block, 64'h28292A2B2C2D2E2F);
    step(0, 0, 1);

    // Idle timeout after a partial block
    for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 1);
    waited = 0;
    do begin
      step(0, 0, 1);
      waited++;
    end while (!tmo && waited < 200);
    chk("tmo_delay", 64'(waited), 64'(T));
    chk("tmo_cnt", 64'(cnt), 64'd0);
    for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), 1);
    chk("tmo_fresh", block, 64'h4041424344454647);
    step(0, 0, 1);

    // Strobe lands on the expiry cycle
    for (int i = 0; i < 3; i++) step(1, 8'(8'h60 + i), 1);
    repeat (T - 1) step(0, 0, 1);
    step(1, 8'h63, 1);
    chk("exp_no_tmo", 64'(tmo), 64'd0);
    chk("exp_cnt", 64'(cnt), 64'd4);
    for (int i = 4; i < 8; i++) step(1, 8'(8'h60 + i), 1);
    chk("exp_blk", block, 64'h6061626364656667);
    step(0, 0, 1);

    // Asynchronous reset mid-block with a pending output
    for (int i = 0; i < 13; i++) step(1, 8'(8'h50 + i), 0);
    chk("pre_rst_cnt", 64'(cnt), 64'd5);
    chk("pre_rst_valid", 64'(valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_block", block, 64'd0);
    chk("arst_cnt", 64'(cnt), 64'd0);
    model_reset();
    fdone = 1'b0;
    ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (5) step(0, 0, 0);

    // Random traffic with occasional long idle gaps
    for (int r = 0; r < 20; r++) begin
      repeat (150) step($urandom % 3 == 0, 8'($urandom), $urandom % 2 == 1);
      repeat ($urandom_range(90, 110)) step(0, 0, $urandom % 2 == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
